// File: rtl/mgc_in_fifo_wait_grn_pkg.sv
// Shared definitions for the wait-handshake FIFO ports.
// Pointer sizing helper and handshake polarity constants.
package mgc_in_fifo_wait_grn_pkg;

  localparam logic HS_ON  = 1'b1;
  localparam logic HS_OFF = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mgc_in_fifo_wait_grn_mem.sv
// Register-array storage for the input FIFO port.
// One write port, asynchronous read, cleared by reset or clear.
module mgc_fifo_mem_grn #(
  parameter int width = 8,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mgc_in_fifo_wait_grn.sv
// Buffered first-word-fall-through input port with wait handshake.
// Producer pushes on vz/lz, core pops on ld/vd; no bypass path.
module mgc_in_fifo_wait_grn
  import mgc_in_fifo_wait_grn_pkg::*;
#(
  parameter int rscid   = 0,
  parameter int width   = 8,
  parameter int fifo_sz = 8,
  parameter int ph_log2 = clog2(fifo_sz)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             srst,
  input  logic             ld,
  output logic             vd,
  output logic [width-1:0] d,
  output logic             lz,
  input  logic             vz,
  input  logic [width-1:0] z,
  output logic [ph_log2:0] size
);

  localparam int PW = (ph_log2 < 1) ? 1 : ph_log2;
  localparam int CW = ph_log2 + 1;
  localparam logic [PW-1:0] LAST = PW'(fifo_sz - 1);

  if (fifo_sz < 1 || rscid < 0) begin : g_bad_cfg
    $error("mgc_in_fifo_wait_grn: invalid configuration");
  end

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          clr;

  assign full  = (count == CW'(fifo_sz));
  assign empty = (count == '0);
  assign lz    = (!full && en) ? HS_ON : HS_OFF;
  assign vd    = (!empty && en) ? HS_ON : HS_OFF;
  assign clr   = en && srst;
  assign push  = vz && lz && !srst;
  assign pop   = ld && vd && !srst;
  assign size  = count;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  mgc_fifo_mem_grn #(
    .width (width),
    .depth (fifo_sz),
    .aw    (PW)
  ) u_mem (
    .clk   (clk),
    .arst  (arst),
    .clr   (clr),
    .we    (push),
    .waddr (wptr),
    .wdata (z),
    .raddr (rptr),
    .rdata (d)
  );

endmodule

// File: tb/tb_mgc_in_fifo_wait_grn.sv
// Bench for mgc_in_fifo_wait_grn: depth-8 and depth-5 instances
// share stimulus and are checked against queue reference models.
module tb_mgc_in_fifo_wait_grn;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       en = 1'b1;
  logic       srst = 1'b0;
  logic       ld = 1'b0;
  logic       vz = 1'b0;
  logic [7:0] z = '0;

  logic       vd8, lz8, vd5, lz5;
  logic [7:0] d8, d5;
  logic [3:0] size8, size5;

  int checks = 0;
  int errors = 0;
  logic [7:0] q8[$];
  logic [7:0] q5[$];

  always #5 clk = ~clk;

  mgc_in_fifo_wait_grn #(
    .rscid(1), .width(8), .fifo_sz(8), .ph_log2(3)
  ) dut8 (
    .clk(clk), .arst(arst), .en(en), .srst(srst),
    .ld(ld), .vd(vd8), .d(d8), .lz(lz8),
    .vz(vz), .z(z), .size(size8)
  );

  mgc_in_fifo_wait_grn #(
    .rscid(2), .width(8), .fifo_sz(5), .ph_log2(3)
  ) dut5 (
    .clk(clk), .arst(arst), .en(en), .srst(srst),
    .ld(ld), .vd(vd5), .d(d5), .lz(lz5),
    .vz(vz), .z(z), .size(size5)
  );

  task automatic model_edge();
    bit p8, r8, p5, r5;
    p8 = vz && (q8.size() < 8);
    r8 = ld && (q8.size() > 0);
    p5 = vz && (q5.size() < 5);
    r5 = ld && (q5.size() > 0);
    if (en) begin
      if (srst) begin
        q8.delete();
        q5.delete();
      end else begin
        if (r8) void'(q8.pop_front());
        if (p8) q8.push_back(z);
        if (r5) void'(q5.pop_front());
        if (p5) q5.push_back(z);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic l,
                       input logic [7:0] data);
    vz = v;
    ld = l;
    z  = data;
    cycle();
  endtask

  task automatic do_arst();
    arst = 1'b0;
    q8.delete();
    q5.delete();
    #1;
    arst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (vd8 !== 1'b0 || vd5 !== 1'b0) begin
      errors++;
      $display("FAIL reset_vd: got %b/%b exp 0", vd8, vd5);
    end
    checks++;
    if (lz8 !== 1'b1 || lz5 !== 1'b1) begin
      errors++;
      $display("FAIL reset_lz: got %b/%b exp 1", lz8, lz5);
    end
    checks++;
    if (size8 !== 4'd0 || size5 !== 4'd0) begin
      errors++;
      $display("FAIL reset_size: got %0d/%0d exp 0", size8, size5);
    end
    checks++;
    if (d8 !== 8'h00 || d5 !== 8'h00) begin
      errors++;
      $display("FAIL reset_d: got %h/%h exp 00", d8, d5);
    end
    arst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [2];
    exp_d[0] = 8'hB2;
    exp_d[1] = 8'hC3;
    do_arst();
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b0, 8'hB2);
    drive(1'b1, 1'b0, 8'hC3);
    vz = 1'b0;
    checks++;
    if (size8 !== 4'd3 || vd8 !== 1'b1 || d8 !== 8'hA1) begin
      errors++;
      $display("FAIL basic_fill: got size=%0d vd=%b d=%h exp 3 1 a1",
               size8, vd8, d8);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      checks++;
      if (i < 2) begin
        if (vd8 !== 1'b1 || d8 !== exp_d[i] || d5 !== exp_d[i]) begin
          errors++;
          $display("FAIL basic_pop%0d: got vd=%b d=%h/%h exp 1 %h",
                   i, vd8, d8, d5, exp_d[i]);
        end
      end else if (vd8 !== 1'b0 || size8 !== 4'd0 || size5 !== 4'd0) begin
        errors++;
        $display("FAIL basic_empty: got vd=%b size=%0d/%0d exp 0 0",
                 vd8, size8, size5);
      end
    end
    ld = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] w [8];
    do_arst();
    for (int i = 0; i < 8; i++) begin
      w[i] = 8'($urandom);
      drive(1'b1, 1'b0, w[i]);
    end
    checks++;
    if (lz8 !== 1'b0 || size8 !== 4'd8 || d8 !== w[0]) begin
      errors++;
      $display("FAIL full8: got lz=%b size=%0d d=%h exp 0 8 %h",
               lz8, size8, d8, w[0]);
    end
    checks++;
    if (lz5 !== 1'b0 || size5 !== 4'd5) begin
      errors++;
      $display("FAIL full5: got lz=%b size=%0d exp 0 5", lz5, size5);
    end
    drive(1'b1, 1'b0, 8'hEE);
    checks++;
    if (size8 !== 4'd8 || d8 !== w[0]) begin
      errors++;
      $display("FAIL full_ignore: got size=%0d d=%h exp 8 %h",
               size8, d8, w[0]);
    end
    drive(1'b1, 1'b1, 8'hDD);
    checks++;
    if (size8 !== 4'd7 || lz8 !== 1'b1 || d8 !== w[1]) begin
      errors++;
      $display("FAIL full_poppush: got size=%0d lz=%b d=%h exp 7 1 %h",
               size8, lz8, d8, w[1]);
    end
    checks++;
    if (size5 !== 4'd4) begin
      errors++;
      $display("FAIL full5_poppush: got size=%0d exp 4", size5);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (d8 !== w[i]) begin
        errors++;
        $display("FAIL full_drain%0d: got %h exp %h", i, d8, w[i]);
      end
      drive(1'b0, 1'b1, 8'h00);
    end
    checks++;
    if (size8 !== 4'd0 || vd8 !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: got size=%0d vd=%b exp 0 0",
               size8, vd8);
    end
    ld = 1'b0;
  endtask

  task automatic test_stream();
    int nxt;
    nxt = 0;
    do_arst();
    for (int i = 0; i < 20; i++) begin
      if (vd5 === 1'b1) begin
        checks++;
        if (d5 !== 8'(nxt)) begin
          errors++;
          $display("FAIL stream_order: got %0d exp %0d", d5, nxt);
        end
        nxt++;
      end
      drive(1'b1, 1'b1, 8'(i));
      checks++;
      if (size5 !== 4'd1) begin
        errors++;
        $display("FAIL stream_size%0d: got %0d exp 1", i, size5);
      end
    end
    checks++;
    if (nxt != 19) begin
      errors++;
      $display("FAIL stream_count: got %0d exp 19", nxt);
    end
    vz = 1'b0;
    ld = 1'b0;
  endtask

  task automatic test_enable();
    do_arst();
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'h33);
      checks++;
      if (vd8 !== 1'b0 || lz8 !== 1'b0 || size8 !== 4'd2 ||
          vd5 !== 1'b0 || lz5 !== 1'b0 || size5 !== 4'd2) begin
        errors++;
        $display("FAIL en_hold%0d: got vd=%b lz=%b size=%0d exp 0 0 2",
                 i, vd8, lz8, size8);
      end
    end
    vz = 1'b0;
    ld = 1'b0;
    en = 1'b1;
    #1;
    checks++;
    if (vd8 !== 1'b1 || d8 !== 8'h11) begin
      errors++;
      $display("FAIL en_resume: got vd=%b d=%h exp 1 11", vd8, d8);
    end
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (d8 !== 8'h22 || size8 !== 4'd1) begin
      errors++;
      $display("FAIL en_pop: got d=%h size=%0d exp 22 1", d8, size8);
    end
    ld = 1'b0;
  endtask

  task automatic test_arst_mid();
    do_arst();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h10 + i));
    vz = 1'b0;
    arst = 1'b0;
    #1;
    checks++;
    if (vd8 !== 1'b0 || size8 !== 4'd0 || d8 !== 8'h00) begin
      errors++;
      $display("FAIL arst_async: got vd=%b size=%0d d=%h exp 0 0 00",
               vd8, size8, d8);
    end
    q8.delete();
    q5.delete();
    arst = 1'b1;
    drive(1'b1, 1'b0, 8'h5A);
    vz = 1'b0;
    checks++;
    if (vd8 !== 1'b1 || d8 !== 8'h5A || size8 !== 4'd1) begin
      errors++;
      $display("FAIL arst_after: got vd=%b d=%h size=%0d exp 1 5a 1",
               vd8, d8, size8);
    end
  endtask

  task automatic test_srst();
    do_arst();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
    srst = 1'b1;
    drive(1'b1, 1'b0, 8'h77);
    srst = 1'b0;
    vz = 1'b0;
    checks++;
    if (size8 !== 4'd0 || vd8 !== 1'b0 || d8 !== 8'h00) begin
      errors++;
      $display("FAIL srst_clear: got size=%0d vd=%b d=%h exp 0 0 00",
               size8, vd8, d8);
    end
    drive(1'b0, 1'b0, 8'h00);
    checks++;
    if (size8 !== 4'd0 || size5 !== 4'd0) begin
      errors++;
      $display("FAIL srst_nostore: got size=%0d/%0d exp 0",
               size8, size5);
    end
  endtask

  task automatic test_random();
    do_arst();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      srst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom), 1'($urandom), 8'($urandom));
      checks++;
      if (vd8 !== (en && q8.size() > 0) ||
          lz8 !== (en && q8.size() < 8) ||
          size8 !== 4'(q8.size())) begin
        errors++;
        $display("FAIL rand8_%0d: got vd=%b lz=%b size=%0d exp size %0d",
                 i, vd8, lz8, size8, q8.size());
      end
      if (q8.size() > 0) begin
        checks++;
        if (d8 !== q8[0]) begin
          errors++;
          $display("FAIL rand8_d%0d: got %h exp %h", i, d8, q8[0]);
        end
      end
      checks++;
      if (vd5 !== (en && q5.size() > 0) ||
          lz5 !== (en && q5.size() < 5) ||
          size5 !== 4'(q5.size())) begin
        errors++;
        $display("FAIL rand5_%0d: got vd=%b lz=%b size=%0d exp size %0d",
                 i, vd5, lz5, size5, q5.size());
      end
      if (q5.size() > 0) begin
        checks++;
        if (d5 !== q5[0]) begin
          errors++;
          $display("FAIL rand5_d%0d: got %h exp %h", i, d5, q5[0]);
        end
      end
    end
    en   = 1'b1;
    srst = 1'b0;
    vz   = 1'b0;
    ld   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_enable();
    test_arst_mid();
    test_srst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mgc_in_fifo_wait_grn.md
# mgc_in_fifo_wait_grn

Buffered input port for the wait-handshake I/O library. It accepts words from an external producer through a valid/load handshake, stores up to `fifo_sz` entries, and presents them first-word-fall-through to the synthesized core's `ld`/`vd` read handshake. It is the receiving counterpart of the output FIFO wait port and lets a core absorb bursty producers without stalling them word by word.

## Interface
- `rscid`, 0: resource ID; carried through for tools, no functional effect.
- `width`, 8: data word width.
- `fifo_sz`, 8: depth in words; must be at least 1; need not be a power of two.
- `ph_log2`, 3: ceil(log2(`fifo_sz`)); pointer width.

Ports:
- `clk`  in  1  rising-edge clock.
- `arst`  in  1  asynchronous reset, active-low.
- `en`  in  1  clock enable, active-high; when 0 the state is frozen and no transfer occurs.
- `srst`  in  1  synchronous clear, active-high; same effect as reset on the next edge when `en`=1.
- `ld`  in  1  core read request.
- `vd`  out  1  core-side valid: FIFO non-empty and `en`=1.
- `d`  out  `width`  head-of-FIFO word.
- `lz`  out  1  external accept: FIFO not full and `en`=1.
- `vz`  in  1  external producer valid.
- `z`  in  `width`  external producer data.
- `size`  out  `ph_log2`+1  current occupancy, 0..`fifo_sz`.

## Operation
- **Push:** `vz && lz` at a clock edge writes `z` to `mem[wptr]`. `wptr` advances, wrapping from `fifo_sz`-1 to 0.
- **Pop:** `ld && vd` at a clock edge advances `rptr` with the same wrap rule. `d` always shows `mem[rptr]`.
- **Count:** `count` increments on push only, decrements on pop only, and is unchanged on push+pop or on neither. `size` = `count`.
- **Flags:** full when `count`==`fifo_sz`; empty when `count`==0. `lz` = !full && `en`. `vd` = !empty && `en`.
- **No bypass:**
  - A word pushed into an empty FIFO is not visible on `d`/`vd` until the following cycle.
  - When full, `lz`=0 even if a pop happens in the same cycle, so no push is accepted.
- **Simultaneous push and pop** when neither full nor empty: both pointers advance and `count` holds.
- **Ignored requests:**
  - `ld` while `vd`=0 is ignored; no pointer movement.
  - `vz` while `lz`=0 is ignored; the producer must hold `z` and `vz` until `lz`=1.
- **Reset and clear** (`arst` low, or `srst` with `en`): `wptr`=`rptr`=0 and `count`=0.
  - Resulting outputs: `vd`=0, `lz`=`en`, `size`=0.
  - `d`=0, because memory entries are also reset to 0.
  - A reset asserted mid-transfer discards all contents. No partial word is retained.
- **`en`=0:** all registers hold, and `vd`=`lz`=0, so neither side can see a transfer.

## Timing
- Push-to-`vd` latency is 1 cycle: a push at edge N gives `vd`=1 after edge N with `d`=that word.
- Pop-to-next-word latency is 0 cycles: after the pop edge, `d` shows the next entry immediately.
- Sustained throughput is 1 word/cycle, with simultaneous push+pop when occupancy is between 1 and `fifo_sz`-1.
- With `fifo_sz`=1 the maximum rate is 1 word per 2 cycles.
- `lz`, `vd` and `size` are functions of registered state plus `en` only. There is no combinational path from `ld` or `vz` to any output.
- `arst` acts asynchronously on assertion. Deassertion takes effect from the first following clock edge.

## Structure
- **Shared package/include:**
  - clog2 function used to derive `ph_log2` defaults.
  - Common handshake polarity constants, shared with the output FIFO port.
- **Sub-module `mgc_fifo_mem_grn`:** `fifo_sz` x `width` register array with one write port, asynchronous read, and async active-low reset. The top level holds the pointers, count and handshake logic.

## Test plan
1. **Basic FWFT:** reset, then push 0xA1, 0xB2, 0xC3 with `ld`=0 → `size`=3, `vd`=1, `d`=0xA1. Then hold `ld`=1 for 3 cycles → `d` shows 0xB2, then 0xC3, then `vd`=0 and `size`=0.
2. **Full boundary** (`fifo_sz`=8): push 8 words → `lz`=0 and `size`=8; a 9th `vz` is ignored. Pop with `vz`=1 in the same cycle → no push that cycle, `lz`=1 next cycle.
3. **Streaming** (`fifo_sz`=5, non-power-of-two): `vz`=`ld`=1 continuously for 20 words 0..19 → output order 0..19, `size` stays 1 after the first cycle, pointers wrap 4→0 correctly.
4. **Clock enable:** with 2 words stored, drop `en` for 3 cycles with `vz`=`ld`=1 → `vd`=`lz`=0, `size`=2, contents unchanged. After `en` returns → pops resume from the original head.
5. **Reset mid-operation:** with 4 words stored, pulse `arst` low between edges → `vd`=0, `size`=0 and `d`=0 immediately. After release, pushing 0x5A → `d`=0x5A one cycle later.
6. **Synchronous clear:** `srst`=1 with `en`=1 and 3 words stored, plus a simultaneous `vz` → after the edge `size`=0 and the pushed word is not stored.
